// File: rtl/nv_nvdla_cmac_rt_pkg.sv
// Shared constants and types for the CMAC->CACC partial-sum retiming pipe.
package nv_nvdla_cmac_rt_pkg;

    localparam int RT_MAX_LATENCY    = 8;
    localparam int CMAC_ATOMK_HALF   = 8;
    localparam int CMAC_RESULT_WIDTH = 19;
    localparam int A2CACC_PD_W       = 9;

    typedef logic [CMAC_RESULT_WIDTH-1:0] a2cacc_lane_t;

    typedef struct packed {
        logic                       vld;
        logic [A2CACC_PD_W-1:0]     pd;
        logic                       mode;
        logic [CMAC_ATOMK_HALF-1:0] mask;
    } a2cacc_beat_t;

endpackage

// File: rtl/nv_nvdla_rt_a2cacc_stage.sv
// One retiming stage: flushable valid/mask, valid-enabled side-band and
// per-lane mask-enabled data with its parity bit.
module nv_nvdla_rt_a2cacc_stage
    import nv_nvdla_cmac_rt_pkg::*;
#(
    parameter int LANES  = CMAC_ATOMK_HALF,
    parameter int DATA_W = CMAC_RESULT_WIDTH,
    parameter int PD_W   = A2CACC_PD_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic [PD_W-1:0]         in_pd,
    input  logic                    in_mode,
    input  logic [LANES-1:0]        in_mask,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_par,
    output logic                    out_vld,
    output logic [PD_W-1:0]         out_pd,
    output logic                    out_mode,
    output logic [LANES-1:0]        out_mask,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_par
);

    logic                    vld_d,  vld_q;
    logic [PD_W-1:0]         pd_d,   pd_q;
    logic                    mode_d, mode_q;
    logic [LANES-1:0]        mask_d, mask_q;
    logic [LANES*DATA_W-1:0] data_d, data_q;
    logic [LANES-1:0]        par_d,  par_q;

    always_comb begin
        vld_d  = in_vld & ~flush;
        mask_d = flush ? '0 : in_mask;
        pd_d   = in_vld ? in_pd : pd_q;
        mode_d = in_vld ? in_mode : mode_q;
        data_d = data_q;
        par_d  = par_q;
        // Lane data moves on its mask bit alone, independent of beat valid.
        for (int k = 0; k < LANES; k++) begin
            if (in_mask[k]) begin
                data_d[k*DATA_W +: DATA_W] = in_data[k*DATA_W +: DATA_W];
                par_d[k]                   = in_par[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            pd_q   <= '0;
            mode_q <= 1'b0;
            mask_q <= '0;
            data_q <= '0;
            par_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            pd_q   <= pd_d;
            mode_q <= mode_d;
            mask_q <= mask_d;
            data_q <= data_d;
            par_q  <= par_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_pd   = pd_q;
    assign out_mode = mode_q;
    assign out_mask = mask_q;
    assign out_data = data_q;
    assign out_par  = par_q;

endmodule

// File: rtl/nv_nvdla_rt_cmac_a2cacc_pipe.sv
// CMAC->CACC retiming pipe: LATENCY stages with flush, in-flight beat count
// and sticky per-lane end-to-end parity checking.
module nv_nvdla_rt_cmac_a2cacc_pipe
    import nv_nvdla_cmac_rt_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int LANES   = CMAC_ATOMK_HALF,
    parameter int DATA_W  = CMAC_RESULT_WIDTH,
    parameter int PD_W    = A2CACC_PD_W,
    parameter int PAR_EN  = 1
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    input  logic                    src_pvld,
    input  logic [PD_W-1:0]         src_pd,
    input  logic                    src_mode,
    input  logic [LANES-1:0]        src_mask,
    input  logic [LANES*DATA_W-1:0] src_data,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic                    dst_pvld,
    output logic [PD_W-1:0]         dst_pd,
    output logic                    dst_mode,
    output logic [LANES-1:0]        dst_mask,
    output logic [LANES*DATA_W-1:0] dst_data,
    output logic [3:0]              inflight_cnt,
    output logic [LANES-1:0]        par_err
);

    // Even parity per lane: the bit that makes the lane plus parity XOR to zero.
    function automatic logic [LANES-1:0] lane_par(input logic [LANES*DATA_W-1:0] d);
        logic [LANES-1:0] p;
        p = '0;
        for (int k = 0; k < LANES; k++) begin
            p[k] = ^d[k*DATA_W +: DATA_W];
        end
        return p;
    endfunction

    if (LATENCY == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok    = ^{nvdla_core_clk, nvdla_core_rstn, flush, err_clr};
        assign dst_pvld     = src_pvld;
        assign dst_pd       = src_pd;
        assign dst_mode     = src_mode;
        assign dst_mask     = src_mask;
        assign dst_data     = src_data;
        assign inflight_cnt = '0;
        assign par_err      = '0;
    end else begin : g_pipe
        logic                    vld_s  [LATENCY+1];
        logic [PD_W-1:0]         pd_s   [LATENCY+1];
        logic                    mode_s [LATENCY+1];
        logic [LANES-1:0]        mask_s [LATENCY+1];
        logic [LANES*DATA_W-1:0] data_s [LATENCY+1];
        logic [LANES-1:0]        par_s  [LATENCY+1];

        logic [3:0]       cnt_d, cnt_q;
        logic [LANES-1:0] err_d, err_q;
        logic [LANES-1:0] mism;

        assign vld_s[0]  = src_pvld;
        assign pd_s[0]   = src_pd;
        assign mode_s[0] = src_mode;
        assign mask_s[0] = src_mask;
        assign data_s[0] = src_data;
        assign par_s[0]  = (PAR_EN != 0) ? lane_par(src_data) : '0;

        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            nv_nvdla_rt_a2cacc_stage #(
                .LANES  (LANES),
                .DATA_W (DATA_W),
                .PD_W   (PD_W)
            ) u_stage (
                .clk      (nvdla_core_clk),
                .rstn     (nvdla_core_rstn),
                .flush    (flush),
                .in_vld   (vld_s[i]),
                .in_pd    (pd_s[i]),
                .in_mode  (mode_s[i]),
                .in_mask  (mask_s[i]),
                .in_data  (data_s[i]),
                .in_par   (par_s[i]),
                .out_vld  (vld_s[i+1]),
                .out_pd   (pd_s[i+1]),
                .out_mode (mode_s[i+1]),
                .out_mask (mask_s[i+1]),
                .out_data (data_s[i+1]),
                .out_par  (par_s[i+1])
            );
        end

        // Set beats clear, so a mismatch in the err_clr cycle is never lost.
        always_comb begin
            cnt_d = cnt_q + {3'b000, src_pvld} - {3'b000, vld_s[LATENCY]};
            if (flush) begin
                cnt_d = '0;
            end
            mism = '0;
            if (PAR_EN != 0 && vld_s[LATENCY]) begin
                mism = (lane_par(data_s[LATENCY]) ^ par_s[LATENCY]) & mask_s[LATENCY];
            end
            err_d = (err_q & ~{LANES{err_clr}}) | mism;
        end

        always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
            if (!nvdla_core_rstn) begin
                cnt_q <= '0;
                err_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end

        assign dst_pvld     = vld_s[LATENCY];
        assign dst_pd       = pd_s[LATENCY];
        assign dst_mode     = mode_s[LATENCY];
        assign dst_mask     = mask_s[LATENCY];
        assign dst_data     = data_s[LATENCY];
        assign inflight_cnt = cnt_q;
        assign par_err      = err_q;
    end

endmodule
